// File: rtl/tx_shaper.sv
// tx_shaper: PRBS9 QPSK symbol source with multiplier-free polyphase pulse shaping and saturating output.
module tx_shaper #(
  parameter int OS = 4,
  parameter int NBAUD = 6,
  parameter int NBT_COEF = 8,
  parameter int NBF_COEF = 7,
  parameter logic [OS*NBAUD*NBT_COEF-1:0] COEFS = '0,
  parameter logic [8:0] SEED_I = 9'h1AA,
  parameter logic [8:0] SEED_Q = 9'h1FE,
  parameter int NBT_OUT = 10,
  parameter int NBF_OUT = 7
) (
  input  logic                      clk,
  input  logic                      i_reset,
  input  logic                      i_en_tx,
  input  logic                      i_valid,
  output logic                      o_valid,
  output logic signed [NBT_OUT-1:0] o_data_I,
  output logic signed [NBT_OUT-1:0] o_data_Q,
  output logic                      o_sym_I,
  output logic                      o_sym_Q,
  output logic                      o_sym_strobe
);
  localparam int PW = OS > 1 ? $clog2(OS) : 1;
  localparam int AW = NBT_COEF + $clog2(NBAUD);
  localparam int SHL = NBF_OUT > NBF_COEF ? NBF_OUT - NBF_COEF : 0;
  localparam int SHR = NBF_OUT < NBF_COEF ? NBF_COEF - NBF_OUT : 0;
  localparam int MAXV = 2 ** (NBT_OUT - 1) - 1;
  localparam int MINV = -(2 ** (NBT_OUT - 1));
  function automatic logic signed [AW-1:0] coef(input int n);
    return AW'($signed(COEFS[n*NBT_COEF +: NBT_COEF]));
  endfunction
  logic [PW-1:0] phase;
  logic tick, new_sym;
  assign tick = i_en_tx & i_valid;
  assign new_sym = tick && phase == '0;
  always_ff @(posedge clk) begin
    if (i_reset) begin
      phase <= '0;
      o_valid <= 1'b0;
      o_sym_strobe <= 1'b0;
    end else begin
      if (tick) phase <= phase == PW'(OS - 1) ? '0 : phase + 1'b1;
      o_valid <= tick;
      o_sym_strobe <= new_sym;
    end
  end
  for (genvar r = 0; r < 2; r++) begin : g_rail
    localparam logic [8:0] SEED = r == 0 ? SEED_I : SEED_Q;
    localparam logic [8:0] INIT = SEED == 9'h000 ? 9'h1FF : SEED;
    logic [8:0] lfsr;
    logic [NBAUD-1:0] sr, sr_nxt;
    logic signed [AW-1:0] acc;
    logic signed [31:0] al;
    logic signed [NBT_OUT-1:0] y, data;
    logic sym;
    // the symbol entering on a phase-0 tick already contributes to that tick's sample
    assign sr_nxt = new_sym ? NBAUD'({sr, lfsr[8]}) : sr;
    always_comb begin
      acc = '0;
      for (int k = 0; k < NBAUD; k++)
        acc = acc + (sr_nxt[k] ? -coef(k * OS + int'(phase)) : coef(k * OS + int'(phase)));
      al = (32'(acc) <<< SHL) >>> SHR;
      y = al > MAXV ? NBT_OUT'(MAXV) : al < MINV ? NBT_OUT'(MINV) : NBT_OUT'(al);
    end
    always_ff @(posedge clk) begin
      if (i_reset) begin
        lfsr <= INIT;
        sr <= '0;
        data <= '0;
        sym <= 1'b0;
      end else if (tick) begin
        sr <= sr_nxt;
        data <= y;
        if (new_sym) begin
          lfsr <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
          sym <= lfsr[8];
        end
      end
    end
  end
  assign o_data_I = g_rail[0].data;
  assign o_data_Q = g_rail[1].data;
  assign o_sym_I = g_rail[0].sym;
  assign o_sym_Q = g_rail[1].sym;
endmodule
